// File: rtl/traffic_light_fsm_if.sv
// ============================================================================
//  Module      : traffic_light_fsm_if
//  Description : Status bundle of the traffic-light sequencing core. It carries
//                the current phase, the remaining-time counter and the
//                phase-end strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_light_fsm_if;
    logic [1:0]  current_state;   // 00 GREEN, 01 YELLOW, 10 RED
    logic        timer_load;      // phase ends and timer reloads this cycle
    logic [31:0] timer;           // remaining ticks in the current phase
    logic        timer_zero;      // timer == 1, the last tick of the phase

    // The sequencing core drives the status.
    modport master (
        output current_state,
        output timer_load,
        output timer,
        output timer_zero
    );

    // Consumers (lamp decode, display) observe it.
    modport slave (
        input current_state,
        input timer_load,
        input timer,
        input timer_zero
    );
endinterface

`default_nettype wire

// File: rtl/traffic_light_fsm.sv
// ============================================================================
//  Module      : traffic_light_fsm
//  Description : GREEN -> YELLOW -> RED phase sequencer. A built-in prescaler
//                produces the timing tick. A 32-bit down-counter holds the
//                remaining ticks of the current phase. The counter counts
//                N..1 and reloads with the next phase duration on the tick
//                where it reads 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_fsm #(
    parameter logic [31:0] GREEN_TIME  = 32'd10,
    parameter logic [31:0] YELLOW_TIME = 32'd3,
    parameter logic [31:0] RED_TIME    = 32'd7,
    parameter logic [31:0] TICK_DIV    = 32'd10_000_000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    traffic_light_fsm_if.master    bus
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_RED     = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    state_t      state_q;
    logic [31:0] timer_q;
    logic [31:0] presc_q;

    state_t      state_d;
    logic [31:0] timer_d;
    logic        tick;
    logic        phase_end;
    logic        state_legal;

    // A divider of 0 or 1 means a tick on every clock. Otherwise the tick
    // fires in the last cycle of each TICK_DIV-long prescaler period.
    assign tick = (TICK_DIV <= 32'd1) ? 1'b1 : (presc_q == (TICK_DIV - 32'd1));

    // The phase ends on the tick where the timer reads 1. A timer stuck at 0
    // is treated the same way, so a corrupted counter can never wrap.
    assign phase_end   = tick && (timer_q <= 32'd1);
    assign state_legal = (state_q != ST_ILLEGAL);

    // Next phase and its duration. These values are used only on a phase end.
    always_comb begin
        state_d = ST_GREEN;
        timer_d = GREEN_TIME;
        case (state_q)
            ST_GREEN: begin
                state_d = ST_YELLOW;
                timer_d = YELLOW_TIME;
            end
            ST_YELLOW: begin
                state_d = ST_RED;
                timer_d = RED_TIME;
            end
            default: begin
                state_d = ST_GREEN;
                timer_d = GREEN_TIME;
            end
        endcase
    end

    // Tick prescaler: counts 0..TICK_DIV-1 and wraps on the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 32'd0;
        end else if (tick) begin
            presc_q <= 32'd0;
        end else begin
            presc_q <= presc_q + 32'd1;
        end
    end

    // Phase FSM and remaining-time counter. An illegal encoding recovers to
    // GREEN at the next edge without waiting for a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_GREEN;
            timer_q <= GREEN_TIME;
        end else if (!state_legal) begin
            state_q <= ST_GREEN;
            timer_q <= GREEN_TIME;
        end else if (phase_end) begin
            state_q <= state_d;
            timer_q <= timer_d;
        end else if (tick) begin
            timer_q <= timer_q - 32'd1;
        end
    end

    assign bus.current_state = state_q;
    assign bus.timer         = timer_q;
    assign bus.timer_zero    = (timer_q == 32'd1);
    assign bus.timer_load    = phase_end;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
// ============================================================================
//  Module      : tb_traffic_light_fsm
//  Description : Directed bench for traffic_light_fsm. It contains three
//                instances:
//                  A : default timing with TICK_DIV=1
//                  B : TICK_DIV=4
//                  C : YELLOW_TIME=1
//                Expected values are computed by hand and are indexed by the
//                number of rising edges since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_fsm;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_fsm_if if_a ();
    traffic_light_fsm_if if_b ();
    traffic_light_fsm_if if_c ();

    traffic_light_fsm #(
        .GREEN_TIME (32'd10), .YELLOW_TIME(32'd3), .RED_TIME(32'd7), .TICK_DIV(32'd1)
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a.master));

    traffic_light_fsm #(
        .GREEN_TIME (32'd10), .YELLOW_TIME(32'd3), .RED_TIME(32'd7), .TICK_DIV(32'd4)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

    traffic_light_fsm #(
        .GREEN_TIME (32'd10), .YELLOW_TIME(32'd1), .RED_TIME(32'd7), .TICK_DIV(32'd1)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c.master));

    always #5 clk = ~clk;

    // Expected state and timer of instance A after k edges, k = 0..20.
    logic [1:0]  exp_a_st  [0:20] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                      2'd0, 2'd0, 2'd0,
                                      2'd1, 2'd1, 2'd1,
                                      2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                      2'd0};
    logic [31:0] exp_a_tm  [0:20] = '{32'd10, 32'd9, 32'd8, 32'd7, 32'd6, 32'd5,
                                      32'd4, 32'd3, 32'd2, 32'd1,
                                      32'd3, 32'd2, 32'd1,
                                      32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2,
                                      32'd1,
                                      32'd10};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_zero;
        logic [31:0] exp_tm;

        // Reset asserts asynchronously, before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_eq("rst_a_state", 32'(if_a.current_state), 32'd0);
        check_eq("rst_a_timer", if_a.timer, 32'd10);
        check_eq("rst_a_load",  32'(if_a.timer_load), 32'd0);
        check_eq("rst_a_zero",  32'(if_a.timer_zero), 32'd0);
        check_eq("rst_c_timer", if_c.timer, 32'd10);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Sample k edges after release, on the falling edge.
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);

            // Instance A: full GREEN/YELLOW/RED cycle.
            if (k <= 20) begin
                exp_zero = (exp_a_tm[k] == 32'd1) ? 32'd1 : 32'd0;
                check_eq($sformatf("a_state_k%0d", k), 32'(if_a.current_state), 32'(exp_a_st[k]));
                check_eq($sformatf("a_timer_k%0d", k), if_a.timer, exp_a_tm[k]);
                check_eq($sformatf("a_zero_k%0d", k),  32'(if_a.timer_zero), exp_zero);
                check_eq($sformatf("a_load_k%0d", k),  32'(if_a.timer_load), exp_zero);
            end

            // Instance B: the timer decrements on every 4th edge, and GREEN
            // lasts 40 clocks.
            if (k < 40) begin
                exp_tm = 32'd10 - 32'(k / 4);
                check_eq($sformatf("b_state_k%0d", k), 32'(if_b.current_state), 32'd0);
                check_eq($sformatf("b_timer_k%0d", k), if_b.timer, exp_tm);
                check_eq($sformatf("b_load_k%0d", k),  32'(if_b.timer_load),
                         (k == 39) ? 32'd1 : 32'd0);
            end else begin
                check_eq("b_state_k40", 32'(if_b.current_state), 32'd1);
                check_eq("b_timer_k40", if_b.timer, 32'd3);
            end

            // Instance C: a one-tick YELLOW phase.
            if (k == 9) begin
                check_eq("c_state_k9", 32'(if_c.current_state), 32'd0);
                check_eq("c_timer_k9", if_c.timer, 32'd1);
            end
            if (k == 10) begin
                check_eq("c_state_k10", 32'(if_c.current_state), 32'd1);
                check_eq("c_timer_k10", if_c.timer, 32'd1);
                check_eq("c_zero_k10",  32'(if_c.timer_zero), 32'd1);
                check_eq("c_load_k10",  32'(if_c.timer_load), 32'd1);
            end
            if (k == 11) begin
                check_eq("c_state_k11", 32'(if_c.current_state), 32'd2);
                check_eq("c_timer_k11", if_c.timer, 32'd7);
            end
        end

        // Mid-phase reset. Restart, run to YELLOW timer=2 (k=11), then reset
        // between clock edges.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (11) @(negedge clk);
        check_eq("mid_pre_state", 32'(if_a.current_state), 32'd1);
        check_eq("mid_pre_timer", if_a.timer, 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_state", 32'(if_a.current_state), 32'd0);
        check_eq("mid_rst_timer", if_a.timer, 32'd10);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("mid_cnt_k%0d", k), if_a.timer, 32'd10 - 32'(k));
            check_eq($sformatf("mid_st_k%0d", k), 32'(if_a.current_state), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
